// File: rtl/sprite_anim_ctrl.sv
// Character sprite animation sequencer: picks the walk/jump frame once per video
// frame and produces the mirrored per-pixel ROM address plus a pipelined hit flag.
module sprite_anim_ctrl #(
    parameter int SPR_W          = 16,
    parameter int SPR_H          = 16,
    parameter int TICKS_PER_STEP = 8,
    parameter int ADDR_W         = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              moving,
    input  logic              facing_left,
    input  logic              jump,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [1:0]        frame_sel,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_hit
);

    localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK1 = 2'd1,
        WALK2 = 2'd2,
        JUMP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [9:0]       lx, ly;
    logic             lface;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            lx    <= '0;
            ly    <= '0;
            lface <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // Shadow copies so position/facing never change mid-frame.
            if (frame_start) begin
                lx    <= sprite_x;
                ly    <= sprite_y;
                lface <= facing_left;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (frame_start) begin
            if (jump) begin
                state_next = JUMP;
                cnt_next   = '0;
            end else begin
                case (state)
                    JUMP: begin
                        state_next = moving ? WALK1 : IDLE;
                        cnt_next   = '0;
                    end
                    IDLE: begin
                        if (moving) begin
                            state_next = WALK1;
                            cnt_next   = '0;
                        end
                    end
                    default: begin
                        if (!moving) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt == LAST_TICK) begin
                            state_next = (state == WALK1) ? WALK2 : WALK1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign frame_sel = state;

    // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping.
    logic [10:0]      dx, dy, lx11, ly11, col_off, row_off;
    logic [COL_W-1:0] col, col_m;
    logic             in_box;

    always_comb begin
        dx      = {1'b0, DrawX};
        dy      = {1'b0, DrawY};
        lx11    = {1'b0, lx};
        ly11    = {1'b0, ly};
        in_box  = (dx >= lx11) && (dx < lx11 + 11'(SPR_W)) &&
                  (dy >= ly11) && (dy < ly11 + 11'(SPR_H));
        col_off = dx - lx11;
        row_off = dy - ly11;
        col     = COL_W'(col_off);
        col_m   = lface ? (COL_W'(SPR_W - 1) - col) : col;
        if (in_box)
            rom_address = ADDR_W'(32'(row_off) * 32'(SPR_W) + 32'(col_m));
        else
            rom_address = '0;
    end

    // Lines up with the palette colour the colour path registers on this same edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            sprite_hit <= 1'b0;
        else
            sprite_hit <= in_box & blank;
    end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Self-checking bench for sprite_anim_ctrl: frame sequencing, address/mirroring,
// edge clipping and asynchronous reset, with a queue of expected hit flags.
module tb_sprite_anim_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       frame_start, moving, facing_left, jump, blank;
    logic [9:0] sprite_x, sprite_y, DrawX, DrawY;
    logic [1:0] frame_sel;
    logic [7:0] rom_address;
    logic       sprite_hit;

    int n_tests = 0;
    int n_fail  = 0;
    logic hit_q[$];

    sprite_anim_ctrl #(
        .SPR_W(16),
        .SPR_H(16),
        .TICKS_PER_STEP(8),
        .ADDR_W(8)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .moving(moving),
        .facing_left(facing_left),
        .jump(jump),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .blank(blank),
        .frame_sel(frame_sel),
        .rom_address(rom_address),
        .sprite_hit(sprite_hit)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents a pixel, checks the address, then checks the hit one edge later.
    task automatic pixel(input int x, input int y, input logic b,
                         input logic exp_hit, input int exp_addr, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        #1;
        check({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
        hit_q.push_back(exp_hit);
        @(posedge vga_clk);
        #1;
        if (hit_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            check({tag, "_hit"}, 32'(sprite_hit), 32'(hit_q.pop_front()));
        end
    endtask

    task automatic pulse(input logic mv, input logic jp, input logic fl,
                         input int sx, input int sy, input int exp_sel, input string tag);
        moving      = mv;
        jump        = jp;
        facing_left = fl;
        sprite_x    = 10'(sx);
        sprite_y    = 10'(sy);
        blank       = 1'b0;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        check(tag, 32'(frame_sel), 32'(exp_sel));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        frame_start = 0; moving = 0; facing_left = 0; jump = 0; blank = 0;
        sprite_x = '0; sprite_y = '0; DrawX = '0; DrawY = '0;
        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_frame_sel", 32'(frame_sel), 32'd0);
        check("rst_hit", 32'(sprite_hit), 32'd0);
        check("rst_addr", 32'(rom_address), 32'd0);
        reset_n = 1'b1;
        @(posedge vga_clk);
        #1;

        // Idle sprite at the origin: hits only inside the top-left 16x16.
        pulse(0, 0, 0, 0, 0, 0, "idle_sel");
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 24; x++) begin
                if (x < 16 && y < 16)
                    pixel(x, y, 1'b1, 1'b1, y * 16 + x, "sweep_in");
                else
                    pixel(x, y, 1'b1, 1'b0, 0, "sweep_out");
            end
        end
        pixel(639, 479, 1'b1, 1'b0, 0, "far_corner");
        pixel(3, 3, 1'b0, 1'b0, 51, "blank_low");

        // Walk cycle: toggles every 8 pulses starting at WALK1.
        for (int n = 1; n <= 40; n++) begin
            pulse(1, 0, 0, 0, 0, (((n - 1) / 8) % 2 == 0) ? 1 : 2, "walk_seq");
        end

        // Pulse 41 toggles to WALK2; latch position (100,200).
        pulse(1, 0, 0, 100, 200, 2, "walk_41");
        pixel(105, 203, 1'b1, 1'b1, 53, "pos_fwd");
        pixel(99, 203, 1'b1, 1'b0, 0, "pos_left_out");
        pixel(116, 203, 1'b1, 1'b0, 0, "pos_right_out");
        facing_left = 1'b1;
        sprite_x = 10'd300;
        pixel(105, 203, 1'b1, 1'b1, 53, "face_unlatched");
        pulse(1, 0, 1, 100, 200, 2, "walk_42");
        pixel(105, 203, 1'b1, 1'b1, 58, "pos_mirror");
        pixel(115, 215, 1'b1, 1'b1, 240, "pos_mirror_corner");
        pixel(100, 216, 1'b1, 1'b0, 0, "pos_bottom_out");

        // Jump from WALK2, then land while moving: counter restarts.
        pulse(1, 1, 1, 100, 200, 3, "jump");
        pulse(1, 1, 1, 100, 200, 3, "jump_hold");
        pulse(1, 0, 1, 100, 200, 1, "land_walk");
        for (int n = 1; n <= 7; n++) begin
            pulse(1, 0, 1, 100, 200, 1, "land_count");
        end
        pulse(1, 0, 1, 100, 200, 2, "land_toggle");
        pulse(0, 0, 0, 630, 470, 0, "stop_idle");

        // Sprite hanging off the bottom-right corner.
        pixel(639, 479, 1'b1, 1'b1, 153, "edge_hit");
        pixel(630, 470, 1'b1, 1'b1, 0, "edge_origin");
        pixel(5, 479, 1'b1, 1'b0, 0, "edge_nowrap");
        pixel(639, 5, 1'b1, 1'b0, 0, "edge_nowrap_y");

        // Mid-line asynchronous reset while walking with hit high.
        pulse(1, 0, 0, 630, 470, 1, "pre_reset_walk");
        pixel(639, 479, 1'b1, 1'b1, 153, "pre_reset_hit");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_hit", 32'(sprite_hit), 32'd0);
        check("async_sel", 32'(frame_sel), 32'd0);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        moving = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        check("post_reset_hold", 32'(frame_sel), 32'd0);
        pixel(3, 2, 1'b1, 1'b1, 35, "post_reset_latch");
        pulse(1, 0, 0, 0, 0, 1, "post_reset_walk");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
Sequences the animation of one character sprite for the VGA path. Picks the active sprite frame (idle / walk1 / walk2 / jump) from movement inputs, advancing once per video frame. Generates the per-pixel ROM address, with horizontal mirroring, for a sprite placed at a screen position. Emits a hit flag aligned with the registered palette colour so the compositor can overlay the sprite on the background.

Parameters:
SPR_W, 16, sprite width in pixels (power of 2)
SPR_H, 16, sprite height in pixels
TICKS_PER_STEP, 8, video frames per walk-frame toggle (>=1)
ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H

Ports:
vga_clk  in  1  pixel clock; all state on posedge
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
moving  in  1  character horizontal motion request
facing_left  in  1  1 = mirror sprite horizontally
jump  in  1  character airborne
sprite_x  in  10  left edge of sprite, screen pixels
sprite_y  in  10  top edge of sprite, screen pixels
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video (same sense as the colour path)
frame_sel  out  2  0 idle, 1 walk1, 2 walk2, 3 jump; selects ROM bank
rom_address  out  ADDR_W  combinational address into the selected sprite ROM
sprite_hit  out  1  registered; 1 when this cycle's registered colour belongs to the sprite

Behaviour:
- Reset (async, reset_n=0): state=IDLE, frame_sel=0, step counter=0, latched x/y=0, latched facing=0, sprite_hit=0. rom_address then follows the combinational rule using the zeroed latches.
- Shadow latch: sprite_x, sprite_y and facing_left are captured only on cycles with frame_start=1. All address math uses the latched values, so no tearing mid-frame.
- FSM states: IDLE, WALK1, WALK2, JUMP. It evaluates only on frame_start=1 and holds otherwise. Priority order, top first:
  - jump=1 -> JUMP, counter=0 (from any state).
  - JUMP, jump=0 -> WALK1 if moving, else IDLE; counter=0.
  - IDLE, moving=1 -> WALK1, counter=0.
  - WALK1/WALK2, moving=0 -> IDLE, counter=0.
  - WALK1/WALK2, moving=1: if counter==TICKS_PER_STEP-1, toggle WALK1<->WALK2 and set counter=0; else counter+1.
- frame_sel is registered and is a direct encoding of state. It changes the cycle after the frame_start pulse, which falls inside blanking.
- Bounds check, combinational:
  - Use 11-bit arithmetic so there is no wrap.
  - in_box = (DrawX >= lx) & (DrawX < lx+SPR_W) & (DrawY >= ly) & (DrawY < ly+SPR_H).
  - A sprite partly off the right or bottom edge clips naturally.
- Address:
  - col = DrawX-lx; if facing latched, col = SPR_W-1-col.
  - row = DrawY-ly.
  - rom_address = row*SPR_W + col, truncated to ADDR_W.
  - When in_box=0, rom_address=0.
- Latency:
  - The ROM samples the address on negedge vga_clk.
  - The colour path registers the palette output on the following posedge.
  - sprite_hit <= in_box & blank on that same posedge, i.e. one posedge after DrawX/DrawY are presented.
- Simultaneous events: if frame_start coincides with a change in jump/moving, the sampled values that cycle decide the transition. Position and facing are latched in the same cycle as the transition.
- Reset asserted mid-line: sprite_hit drops immediately (async) and the FSM returns to IDLE. On release, nothing advances until the next frame_start.

Test Plan:
- Reset, then frame_start with all inputs 0 -> frame_sel=0, sprite_hit=0 for a full 640x480 sweep with sprite at (0,0) latched. The top-left 16x16 region gives sprite_hit=1 only at DrawX<16, DrawY<16.
- moving=1, TICKS_PER_STEP=8, 40 frame_start pulses:
  - frame_sel=1 after pulse 1.
  - Toggles to 2 after pulse 9, back to 1 after pulse 17.
  - Continues toggling every 8 pulses.
- Sprite latched at (100,200), facing_left=0, DrawX=105, DrawY=203 -> rom_address=3*16+5=53. sprite_hit=1 one posedge later (blank=1).
- Same point with facing_left=1 -> rom_address=3*16+10=58. facing_left toggled between pulses does not change the address until the next frame_start.
- jump=1 while in WALK2 at a frame_start -> JUMP (frame_sel=3). Then jump=0 with moving=1 -> WALK1, counter restarted (next toggle 8 pulses later).
- Sprite at (630,470): DrawX=639, DrawY=479 -> hit, rom_address=9*16+9=153. DrawX=5 gives no hit (no wrap). Assert reset_n=0 mid-line -> sprite_hit=0 and frame_sel=0 immediately.
